mips_mc_control: RTL and testbench

Multi-cycle main control FSM for the MIPS core. It drives the ALU from the control side: it generates `alu_op` using the same 4-bit encoding the ALU decodes, and it consumes the ALU `zero` flag for branches. It sequences fetch, decode, execute, memory and writeback across cycles over a shared memory port with a ready handshake, and emits every datapath enable and mux select.

---
 rtl/mips_mc_control_if.sv | 36 +++
 rtl/mips_mc_control.sv | 159 +++++++++++++++
 tb/tb_mips_mc_control.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_control_if.sv
// Control <-> datapath/memory bundle for the multi-cycle MIPS main controller.
// The controller is the master; the datapath and memory form the slave side.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_instr;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_instr, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_instr, state
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM: registered state, outputs decoded from the
// current state plus same-cycle mem_ready/zero.
module mips_mc_control (
  input  logic                clk,
  input  logic                rst_n,
  mips_mc_control_if.master   bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic [3:0] w_rtype_op;

  logic       w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_reg_write;
  logic       w_reg_dst, w_mem_to_reg, w_alu_src_a, w_pc_en, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_src;
  logic [3:0] w_alu_op;

  always_comb begin
    w_funct_ok = 1'b1;
    w_rtype_op = ALU_ADD;
    case (bus.funct)
      6'b100000: w_rtype_op = ALU_ADD;
      6'b100010: w_rtype_op = ALU_SUB;
      6'b100100: w_rtype_op = ALU_AND;
      6'b100101: w_rtype_op = ALU_OR;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = FETCH;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_i_or_d    = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_reg_dst   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 2'b00;
    w_alu_op    = ALU_ADD;
    w_pc_src    = 2'b00;
    w_pc_en     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_en     = bus.mem_ready;
        w_next      = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          OP_RTYPE: begin
            w_next    = w_funct_ok ? RTYPEEX : FETCH;
            w_illegal = ~w_funct_ok;
          end
          default:      w_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_i_or_d   = 1'b1;
        w_mem_read = 1'b1;
        w_next     = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      MEMWR: begin
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
        w_next      = bus.mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = w_rtype_op;
        w_next      = RTYPEWB;
      end
      RTYPEWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      BEQEX: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_SUB;
        w_pc_src    = 2'b01;
        w_pc_en     = bus.zero;
      end
      ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = ADDIWB;
      end
      ADDIWB:  w_reg_write = 1'b1;
      JEX: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // Side-effecting strobes are gated by rst_n so an asserted reset aborts any
  // write or PC/IR load at once, before the state register is even observed.
  assign bus.ir_write      = w_ir_write  & rst_n;
  assign bus.pc_en         = w_pc_en     & rst_n;
  assign bus.reg_write     = w_reg_write & rst_n;
  assign bus.mem_write     = w_mem_write & rst_n;
  assign bus.illegal_instr = w_illegal   & rst_n;

  assign bus.mem_read   = w_mem_read;
  assign bus.i_or_d     = w_i_or_d;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.pc_src     = w_pc_src;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: instruction-level model expands each instruction
// into its expected per-cycle outputs; one loop drives inputs and compares.
module tb_mips_mc_control;
  logic clk;
  logic rst_n;
  mips_mc_control_if bus();

  mips_mc_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_write, i_or_d, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en, illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       mr;
    logic       z;
    outs_t      e;
  } cyc_t;

  typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_ILOP, K_ILFN} kind_e;

  cyc_t       q[$];
  logic [3:0] obs[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         ill_count;
  logic [5:0] cur_op, cur_fn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.st = bus.state;         o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
    o.i_or_d = bus.i_or_d;    o.ir_write = bus.ir_write;   o.reg_write = bus.reg_write;
    o.reg_dst = bus.reg_dst;  o.mem_to_reg = bus.mem_to_reg; o.alu_src_a = bus.alu_src_a;
    o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;    o.pc_src = bus.pc_src;
    o.pc_en = bus.pc_en;      o.illegal = bus.illegal_instr;
    return o;
  endfunction

  function automatic outs_t base(input int st);
    outs_t o = '0;
    o.st     = 4'(st);
    o.alu_op = 4'b0010;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic outs_t fetch_vec(input logic mr, input logic in_rst);
    outs_t o = base(0);
    o.mem_read  = 1'b1;
    o.alu_src_b = 2'b01;
    o.ir_write  = mr & ~in_rst;
    o.pc_en     = mr & ~in_rst;
    return o;
  endfunction

  task automatic push(input logic mr, input logic z, input outs_t e);
    cyc_t c;
    c.op = cur_op; c.fn = cur_fn; c.mr = mr; c.z = z; c.e = e;
    q.push_back(c);
  endtask

  // A memory phase: 'stalls' cycles with mem_ready low, then one completing cycle.
  task automatic push_wait(input int stalls, input outs_t e);
    for (int i = 0; i < stalls; i++) push(1'b0, rb(), e);
    push(1'b1, rb(), e);
  endtask

  task automatic plan_instr(input kind_e k, input int fs, input int ms,
                            input logic [5:0] fn, input logic z);
    outs_t e;
    case (k)
      K_LW:   cur_op = 6'h23;
      K_SW:   cur_op = 6'h2b;
      K_BEQ:  cur_op = 6'h04;
      K_ADDI: cur_op = 6'h08;
      K_J:    cur_op = 6'h02;
      K_ILOP: cur_op = 6'h3f;
      default: cur_op = 6'h00;
    endcase
    cur_fn = fn;
    for (int i = 0; i < fs; i++) push(1'b0, rb(), fetch_vec(1'b0, 1'b0));
    push(1'b1, rb(), fetch_vec(1'b1, 1'b0));
    e = base(1); e.alu_src_b = 2'b11; e.illegal = (k == K_ILOP || k == K_ILFN);
    push(rb(), rb(), e);
    if (k == K_LW || k == K_SW) begin
      e = base(2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      push(rb(), rb(), e);
    end
    case (k)
      K_LW: begin
        e = base(3); e.i_or_d = 1'b1; e.mem_read = 1'b1; push_wait(ms, e);
        e = base(4); e.mem_to_reg = 1'b1; e.reg_write = 1'b1; push(rb(), rb(), e);
      end
      K_SW: begin
        e = base(5); e.i_or_d = 1'b1; e.mem_write = 1'b1; push_wait(ms, e);
      end
      K_R: begin
        e = base(6); e.alu_src_a = 1'b1; e.alu_op = funct_alu(fn); push(rb(), rb(), e);
        e = base(7); e.reg_dst = 1'b1; e.reg_write = 1'b1; push(rb(), rb(), e);
      end
      K_BEQ: begin
        e = base(8); e.alu_src_a = 1'b1; e.alu_op = 4'b0110; e.pc_src = 2'b01; e.pc_en = z;
        push(rb(), z, e);
      end
      K_ADDI: begin
        e = base(9); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(rb(), rb(), e);
        e = base(10); e.reg_write = 1'b1; push(rb(), rb(), e);
      end
      K_J: begin
        e = base(11); e.pc_src = 2'b10; e.pc_en = 1'b1; push(rb(), rb(), e);
      end
      default: ;
    endcase
  endtask

  // Entered just after a falling edge; leaves just after a falling edge.
  task automatic run_plan();
    cyc_t  c;
    outs_t act;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.opcode = c.op; bus.funct = c.fn; bus.mem_ready = c.mr; bus.zero = c.z;
      #1;
      act = sample();
      check($sformatf("cyc%0d st%0d", cyc, c.e.st), 32'(act), 32'(c.e));
      obs.push_back(act.st);
      if (act.illegal) ill_count++;
      cyc++;
      @(negedge clk);
    end
  endtask

  localparam logic [3:0] LW_SEQ [11] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
  localparam logic [5:0] LEGAL_FN [4] = '{6'h20, 6'h22, 6'h24, 6'h25};

  initial begin
    kind_e      k;
    logic [5:0] fn;
    outs_t      act;

    rst_n = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3;
    check("reset vector", 32'(sample()), 32'(fetch_vec(1'b1, 1'b1)));
    check("reset alu_op", 32'(bus.alu_op), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    // lw with 2 fetch stalls and 3 read stalls, followed by j
    obs.delete();
    plan_instr(K_LW, 2, 3, 6'h11, 1'b0);
    plan_instr(K_J, 0, 0, 6'h00, 1'b0);
    run_plan();
    for (int i = 0; i < 11; i++) check($sformatf("lw state seq %0d", i), 32'(obs[i]), 32'(LW_SEQ[i]));

    for (int i = 0; i < 4; i++) begin
      plan_instr(K_R, 0, 0, LEGAL_FN[i], 1'b0);
      run_plan();
    end
    plan_instr(K_BEQ, 0, 0, 6'h00, 1'b1);
    plan_instr(K_BEQ, 1, 0, 6'h00, 1'b0);
    plan_instr(K_SW, 1, 2, 6'h00, 1'b0);
    plan_instr(K_ADDI, 0, 0, 6'h00, 1'b0);
    run_plan();

    ill_count = 0;
    plan_instr(K_ILOP, 0, 0, 6'h00, 1'b0);
    run_plan();
    check("illegal op pulses", 32'(ill_count), 32'd1);
    ill_count = 0;
    plan_instr(K_ILFN, 1, 0, 6'h2a, 1'b0);
    run_plan();
    check("illegal funct pulses", 32'(ill_count), 32'd1);

    // sw stalled in MEMWR, then reset mid-cycle
    plan_instr(K_SW, 0, 0, 6'h00, 1'b0);
    void'(q.pop_back());
    begin
      outs_t e = base(5);
      e.i_or_d = 1'b1; e.mem_write = 1'b1;
      push(1'b0, 1'b0, e);
      push(1'b0, 1'b0, e);
    end
    run_plan();
    bus.mem_ready = 1'b0;
    #1;
    check("sw stalled mem_write", 32'(bus.mem_write), 32'd1);
    check("sw stalled state", 32'(bus.state), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    act = sample();
    check("mid-sw reset vector", 32'(act), 32'(fetch_vec(1'b0, 1'b1)));
    check("mid-sw reset mem_write", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    check("held reset state", 32'(bus.state), 32'd0);
    rst_n = 1'b1;
    plan_instr(K_LW, 0, 0, 6'h00, 1'b0);
    run_plan();

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      k = kind_e'($urandom_range(0, 7));
      fn = 6'($urandom);
      if (k == K_R) fn = LEGAL_FN[$urandom_range(0, 3)];
      if (k == K_ILFN) while (fn inside {6'h20, 6'h22, 6'h24, 6'h25}) fn = 6'($urandom);
      plan_instr(k, $urandom_range(0, 2), $urandom_range(0, 3), fn, rb());
      if (k == K_ILOP) begin
        cur_op = 6'($urandom);
        while (cur_op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2b}) cur_op = 6'($urandom);
        foreach (q[i]) q[i].op = cur_op;
      end
      run_plan();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
